// File: rtl/top_7_segments_if.sv
// Bus-side view of the stopwatch/display peripheral: control write port plus
// the active-low segment and digit-enable drives.
interface top_7_segments_if;
  logic [31:0] activation;
  logic        we_7seg;
  logic        a, b, c, d, e, f, g;
  logic [7:0]  AN;

  modport master (
    output activation, we_7seg,
    input  a, b, c, d, e, f, g, AN
  );

  modport slave (
    input  activation, we_7seg,
    output a, b, c, d, e, f, g, AN
  );
endinterface

// File: rtl/top_7_segments.sv
// Stopwatch peripheral: START/STOP writes control a 32-bit cycle counter, and
// the latched result is scanned onto an 8-digit common-anode hex display.
module top_7_segments #(
  parameter int REFRESH_CYCLES = 4
) (
  input logic             clk,
  input logic             rst,
  top_7_segments_if.slave bus
);

  localparam int PW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(REFRESH_CYCLES - 1);

  logic [31:0]   count;
  logic          running;
  logic [31:0]   disp;
  logic [PW-1:0] prescaler;
  logic [2:0]    digit;

  logic start, stop;
  assign start = bus.activation[0];
  assign stop  = bus.activation[1];

  // Upper control bits carry no meaning; folded here so they are visibly consumed.
  logic ctrl_unused;
  assign ctrl_unused = ^bus.activation[31:2];

  // NOTE: state registers use non-blocking assignments so every register sees
  // the pre-edge value of the others, matching the hardware it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      running   <= 1'b0;
      disp      <= '0;
      prescaler <= '0;
      digit     <= '0;
    end else begin
      if (bus.we_7seg && stop) begin
        running <= 1'b0;
        disp    <= count;
      end else if (bus.we_7seg && start) begin
        count   <= '0;
        running <= 1'b1;
      end else if (running) begin
        count <= count + 32'd1;
      end

      if (prescaler == PRESCALE_MAX) begin
        prescaler <= '0;
        digit     <= digit + 3'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  logic [3:0] nibble;
  logic [6:0] segs;  // {a,b,c,d,e,f,g}, 0 = lit

  assign nibble = disp[{digit, 2'b00} +: 4];

  // NOTE: the default assignment before the case keeps this block purely
  // combinational; without it a missed branch would infer a latch.
  always_comb begin
    segs = 7'b1111111;
    case (nibble)
      4'h0: segs = 7'b0000001;
      4'h1: segs = 7'b1001111;
      4'h2: segs = 7'b0010010;
      4'h3: segs = 7'b0000110;
      4'h4: segs = 7'b1001100;
      4'h5: segs = 7'b0100100;
      4'h6: segs = 7'b0100000;
      4'h7: segs = 7'b0001111;
      4'h8: segs = 7'b0000000;
      4'h9: segs = 7'b0000100;
      4'hA: segs = 7'b0001000;
      4'hB: segs = 7'b1100000;
      4'hC: segs = 7'b0110001;
      4'hD: segs = 7'b1000010;
      4'hE: segs = 7'b0110000;
      4'hF: segs = 7'b0111000;
      default: segs = 7'b1111111;
    endcase
  end

  assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = segs;
  assign bus.AN = ~(8'b1 << digit);

endmodule

// File: tb/tb_top_7_segments.sv
// Self-checking bench for top_7_segments: table-driven stopwatch runs, corner
// sequences and a randomized phase against a behavioural stopwatch model.
module tb_top_7_segments;

  localparam int R = 4;

  logic clk = 1'b0;
  logic rst;
  top_7_segments_if bus ();

  top_7_segments #(.REFRESH_CYCLES(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: stopwatch value plus number of edges since reset.
  logic [31:0] m_count;
  bit          m_running;
  logic [31:0] m_disp;
  int          m_cyc;

  string lit_map[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                         "acdefg", "abc", "abcdefg", "abcdfg", "abcefg", "cdefg",
                         "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] ref_segs(logic [3:0] v);
    string names = "abcdefg";
    string lit   = lit_map[v];
    logic [6:0] r = '1;
    for (int s = 0; s < 7; s++)
      for (int k = 0; k < lit.len(); k++)
        if (lit[k] == names[s]) r[6-s] = 1'b0;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic check_against(string tag, logic [31:0] exp_disp);
    int dig = (m_cyc / R) % 8;
    logic [3:0] nib = 4'((exp_disp >> (4 * dig)) & 32'hF);
    check({tag, "_an"}, {24'd0, bus.AN}, {24'd0, ~(8'd1 << dig)});
    check({tag, "_seg"}, {25'd0, bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g},
          {25'd0, ref_segs(nib)});
  endtask

  // Apply one clock with the given inputs, advance the model, then compare.
  task automatic cycle(bit r, logic [31:0] act, bit we);
    rst            = r;
    bus.activation = act;
    bus.we_7seg    = we;
    @(posedge clk);
    #1;
    if (r) begin
      m_count = 0; m_running = 0; m_disp = 0; m_cyc = 0;
    end else begin
      if (we && act[1]) begin
        m_running = 0;
        m_disp    = m_count;
      end else if (we && act[0]) begin
        m_count   = 0;
        m_running = 1;
      end else if (m_running) begin
        m_count = m_count + 1;
      end
      m_cyc++;
    end
    check_against("model", m_disp);
  endtask

  typedef struct {
    int          idle;
    logic [31:0] stop_word;
    logic [31:0] exp_disp;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] prev_exp;

  initial begin
    vecs[0] = '{idle: 100, stop_word: 32'h2,         exp_disp: 32'h64};
    vecs[1] = '{idle: 75,  stop_word: 32'h2,         exp_disp: 32'h4B};
    vecs[2] = '{idle: 0,   stop_word: 32'h2,         exp_disp: 32'h0};
    vecs[3] = '{idle: 7,   stop_word: 32'h3,         exp_disp: 32'h7};
    vecs[4] = '{idle: 3,   stop_word: 32'hFFFF_FFFE, exp_disp: 32'h3};

    m_count = 0; m_running = 0; m_disp = 0; m_cyc = 0;
    bus.activation = '0;
    bus.we_7seg    = 1'b0;
    rst            = 1'b1;

    // Reset state, including a START write that reset must override.
    cycle(1, 32'h0, 0);
    cycle(1, 32'h1, 1);
    check("reset_an", {24'd0, bus.AN}, 32'hFE);
    check("reset_seg", {25'd0, bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g}, 32'h01);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 32'h0, 0);
      check_against("idle", 32'h0);
    end

    // Table-driven START / idle / STOP runs; display must hold the old value.
    prev_exp = 32'h0;
    for (int v = 0; v < 5; v++) begin
      cycle(0, 32'h1, 1);
      check_against("tbl_start_hold", prev_exp);
      for (int i = 0; i < vecs[v].idle; i++) begin
        cycle(0, 32'h0, 0);
        check_against("tbl_hold", prev_exp);
      end
      cycle(0, vecs[v].stop_word, 1);
      for (int i = 0; i < 8 * R; i++) begin
        check_against($sformatf("tbl%0d", v), vecs[v].exp_disp);
        cycle(0, 32'h0, 0);
      end
      prev_exp = vecs[v].exp_disp;
    end

    // Restart while running clears the count.
    cycle(0, 32'h1, 1);
    for (int i = 0; i < 20; i++) cycle(0, 32'h0, 0);
    cycle(0, 32'h1, 1);
    for (int i = 0; i < 5; i++) cycle(0, 32'h0, 0);
    cycle(0, 32'h2, 1);
    for (int i = 0; i < 8 * R; i++) begin
      check_against("restart", 32'h5);
      cycle(0, 32'h0, 0);
    end

    // STOP while idle re-latches the held count.
    cycle(0, 32'h2, 1);
    check_against("idle_stop", 32'h5);

    // A write of 00 mid-count leaves counting untouched: 10 + 1 + 9 edges.
    cycle(0, 32'h1, 1);
    for (int i = 0; i < 10; i++) cycle(0, 32'h0, 0);
    cycle(0, 32'hFFFF_FFFC, 1);
    for (int i = 0; i < 9; i++) cycle(0, 32'h0, 0);
    cycle(0, 32'h2, 1);
    for (int i = 0; i < 8 * R; i++) begin
      check_against("nop_write", 32'h14);
      cycle(0, 32'h0, 0);
    end

    // Reset coinciding with a STOP write mid-count.
    cycle(0, 32'h1, 1);
    for (int i = 0; i < 30; i++) cycle(0, 32'h0, 0);
    cycle(1, 32'h2, 1);
    check("rst_stop_an", {24'd0, bus.AN}, 32'hFE);
    check("rst_stop_seg", {25'd0, bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g}, 32'h01);
    for (int i = 0; i < 8 * R; i++) begin
      cycle(0, 32'h0, 0);
      check_against("rst_stop", 32'h0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 299) == 0, $urandom, $urandom_range(0, 11) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
